// File: rtl/multicycle_pkg.sv
// +--------------------------------------------------------------------+
// | multicycle_pkg: states, opcodes, ALU codes and datapath selects    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_ALU_WB,
    S_MEM_ADDR, S_LOAD_MEM, S_LOAD_WB, S_STORE_MEM,
    S_BRANCH_CMP, S_BRANCH_TAKEN, S_LINK, S_JUMP,
    S_LUI, S_AUIPC, S_NEXT_PC, S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    ALU_CLASS_ADD, ALU_CLASS_OP, ALU_CLASS_OP_IMM, ALU_CLASS_BRANCH
  } alu_class_t;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;

  localparam logic       OPA_RS1 = 1'b0;
  localparam logic       OPA_PC  = 1'b1;
  localparam logic [1:0] OPB_RS2  = 2'd0;
  localparam logic [1:0] OPB_IMM  = 2'd1;
  localparam logic [1:0] OPB_FOUR = 2'd2;
  localparam logic [1:0] OPB_ZERO = 2'd3;
  localparam logic [2:0] WB_ALU_OUT = 3'd0;
  localparam logic [2:0] WB_DATA    = 3'd1;
  localparam logic [2:0] WB_PC      = 3'd2;
  localparam logic [2:0] WB_IMM     = 3'd3;
  localparam logic       NPC_ALU_RESULT = 1'b0;
  localparam logic       NPC_ALU_OUT    = 1'b1;

  // BEQ/BGE/BGEU take on a zero result, BNE/BLT/BLTU on a non-zero one
  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
    return zero ^ (funct3[0] ^ funct3[2]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_control.sv
// +--------------------------------------------------------------------+
// | alu_control: maps (class, funct3, funct7) to an ALU function code  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_control
  import multicycle_pkg::*;
(
  input  alu_class_t  alu_class,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output logic [4:0]  alu_function
);

  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    alu_function = ALU_ADD;
    case (alu_class)
      ALU_CLASS_OP, ALU_CLASS_OP_IMM: begin
        case (funct3)
          3'b000: alu_function = (alu_class == ALU_CLASS_OP && funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b001: alu_function = ALU_SLL;
          3'b010: alu_function = ALU_SLT;
          3'b011: alu_function = ALU_SLTU;
          3'b100: alu_function = ALU_XOR;
          3'b101: alu_function = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110: alu_function = ALU_OR;
          default: alu_function = ALU_AND;
        endcase
      end
      ALU_CLASS_BRANCH: begin
        case (funct3[2:1])
          2'b00:   alu_function = ALU_SUB;
          2'b10:   alu_function = ALU_SLT;
          2'b11:   alu_function = ALU_SLTU;
          default: alu_function = ALU_ADD;
        endcase
      end
      default: alu_function = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// +--------------------------------------------------------------------+
// | multicycle_control: Moore FSM sequencing the multicycle RV32I path |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module multicycle_control
  import multicycle_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] inst_opcode,
  input  logic [2:0] inst_funct3,
  input  logic [6:0] inst_funct7,
  input  logic       alu_result_equal_zero,
  output logic [4:0] alu_function,
  output logic       alu_operand_a_select,
  output logic [1:0] alu_operand_b_select,
  output logic       next_pc_select,
  output logic       pc_write_enable,
  output logic       alu_out_write_enable,
  output logic       inst_write_enable,
  output logic       data_write_enable,
  output logic       regfile_write_enable,
  output logic [2:0] reg_writeback_select,
  output logic       inst_or_data,
  output logic       mem_read_enable,
  output logic       mem_write_enable,
  output logic       illegal_inst
);

  state_t     state_q, state_d;
  alu_class_t alu_class;
  logic       do_pc_plus_4;

  alu_control u_alu_control (
    .alu_class    (alu_class),
    .funct3       (inst_funct3),
    .funct7       (inst_funct7),
    .alu_function (alu_function)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (inst_opcode)
          OPC_OP, OPC_OP_IMM:  state_d = S_EXECUTE;
          OPC_LOAD, OPC_STORE: state_d = S_MEM_ADDR;
          OPC_BRANCH:          state_d = S_BRANCH_CMP;
          OPC_JAL, OPC_JALR:   state_d = S_LINK;
          OPC_LUI:             state_d = S_LUI;
          OPC_AUIPC:           state_d = S_AUIPC;
          OPC_MISC_MEM:        state_d = S_NEXT_PC;
          default:             state_d = S_TRAP;
        endcase
      end
      S_EXECUTE, S_AUIPC: state_d = S_ALU_WB;
      S_MEM_ADDR: state_d = (inst_opcode == OPC_LOAD) ? S_LOAD_MEM : S_STORE_MEM;
      S_LOAD_MEM: state_d = S_LOAD_WB;
      S_BRANCH_CMP: begin
        if (inst_funct3[2:1] == 2'b01)
          state_d = S_TRAP;
        else if (branch_taken(inst_funct3, alu_result_equal_zero))
          state_d = S_BRANCH_TAKEN;
        else
          state_d = S_NEXT_PC;
      end
      S_LINK: state_d = S_JUMP;
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    alu_class            = ALU_CLASS_ADD;
    alu_operand_a_select = OPA_RS1;
    alu_operand_b_select = OPB_RS2;
    next_pc_select       = NPC_ALU_RESULT;
    reg_writeback_select = WB_ALU_OUT;
    inst_or_data         = 1'b0;
    pc_write_enable      = 1'b0;
    alu_out_write_enable = 1'b0;
    inst_write_enable    = 1'b0;
    data_write_enable    = 1'b0;
    regfile_write_enable = 1'b0;
    mem_read_enable      = 1'b0;
    mem_write_enable     = 1'b0;
    illegal_inst         = 1'b0;
    do_pc_plus_4         = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_enable   = 1'b1;
        inst_write_enable = 1'b1;
      end
      S_EXECUTE: begin
        alu_class            = (inst_opcode == OPC_OP) ? ALU_CLASS_OP : ALU_CLASS_OP_IMM;
        alu_operand_b_select = (inst_opcode == OPC_OP) ? OPB_RS2 : OPB_IMM;
        alu_out_write_enable = 1'b1;
      end
      S_ALU_WB, S_LOAD_WB: begin
        regfile_write_enable = 1'b1;
        reg_writeback_select = (state_q == S_LOAD_WB) ? WB_DATA : WB_ALU_OUT;
        do_pc_plus_4         = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_operand_b_select = OPB_IMM;
        alu_out_write_enable = 1'b1;
      end
      S_LOAD_MEM: begin
        inst_or_data      = 1'b1;
        mem_read_enable   = 1'b1;
        data_write_enable = 1'b1;
      end
      S_STORE_MEM: begin
        inst_or_data     = 1'b1;
        mem_write_enable = 1'b1;
        do_pc_plus_4     = 1'b1;
      end
      S_BRANCH_CMP: alu_class = ALU_CLASS_BRANCH;
      S_BRANCH_TAKEN, S_AUIPC: begin
        alu_operand_a_select = OPA_PC;
        alu_operand_b_select = OPB_IMM;
        pc_write_enable      = (state_q == S_BRANCH_TAKEN);
        alu_out_write_enable = (state_q == S_AUIPC);
      end
      S_LINK: begin
        alu_operand_a_select = OPA_PC;
        alu_operand_b_select = OPB_FOUR;
        alu_out_write_enable = 1'b1;
      end
      // alu_out already holds the link address; the ALU computes the target
      S_JUMP: begin
        alu_operand_a_select = (inst_opcode == OPC_JAL) ? OPA_PC : OPA_RS1;
        alu_operand_b_select = OPB_IMM;
        regfile_write_enable = 1'b1;
        pc_write_enable      = 1'b1;
      end
      S_LUI: begin
        regfile_write_enable = 1'b1;
        reg_writeback_select = WB_IMM;
        do_pc_plus_4         = 1'b1;
      end
      S_NEXT_PC: do_pc_plus_4 = 1'b1;
      S_TRAP:    illegal_inst = 1'b1;
      default: ;
    endcase
    if (do_pc_plus_4) begin
      alu_operand_a_select = OPA_PC;
      alu_operand_b_select = OPB_FOUR;
      pc_write_enable      = 1'b1;
    end
    if (reset) begin
      pc_write_enable      = 1'b0;
      alu_out_write_enable = 1'b0;
      inst_write_enable    = 1'b0;
      data_write_enable    = 1'b0;
      regfile_write_enable = 1'b0;
      mem_read_enable      = 1'b0;
      mem_write_enable     = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// Bench: drives multicycle_control through a behavioural datapath and compares
// architectural results against an instruction-level reference model.
`default_nettype none

module tb_multicycle_control;
  import multicycle_pkg::*;

  logic       clock, reset;
  logic [6:0] inst_opcode, inst_funct7;
  logic [2:0] inst_funct3;
  logic       alu_result_equal_zero;
  logic [4:0] alu_function;
  logic       alu_operand_a_select, next_pc_select;
  logic [1:0] alu_operand_b_select;
  logic       pc_write_enable, alu_out_write_enable, inst_write_enable;
  logic       data_write_enable, regfile_write_enable;
  logic [2:0] reg_writeback_select;
  logic       inst_or_data, mem_read_enable, mem_write_enable, illegal_inst;

  multicycle_control dut (
    .clock(clock), .reset(reset),
    .inst_opcode(inst_opcode), .inst_funct3(inst_funct3), .inst_funct7(inst_funct7),
    .alu_result_equal_zero(alu_result_equal_zero), .alu_function(alu_function),
    .alu_operand_a_select(alu_operand_a_select), .alu_operand_b_select(alu_operand_b_select),
    .next_pc_select(next_pc_select), .pc_write_enable(pc_write_enable),
    .alu_out_write_enable(alu_out_write_enable), .inst_write_enable(inst_write_enable),
    .data_write_enable(data_write_enable), .regfile_write_enable(regfile_write_enable),
    .reg_writeback_select(reg_writeback_select), .inst_or_data(inst_or_data),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .illegal_inst(illegal_inst)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- ISA helpers ----------------
  function automatic logic [31:0] imm_of(input logic [31:0] ins);
    case (ins[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM: return {{20{ins[31]}}, ins[31:20]};
      OPC_STORE:  return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OPC_BRANCH: return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: return {ins[31:12], 12'b0};
      OPC_JAL:    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default:    return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction
  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm[11:0], rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
  endfunction
  function automatic logic [31:0] enc_u(input logic [31:0] imm20, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm20[19:0], rd, opc};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
  endfunction

  // ---------------- behavioural datapath ----------------
  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  logic [31:0] dp_rf [32];
  logic [31:0] dp_pc, dp_ir, dp_rs1, dp_rs2, dp_alu_out, dp_data;
  logic [31:0] dp_imm, alu_a, alu_b, alu_result, mem_rdata, wb_value, next_pc;
  logic        dp_clear;

  assign inst_opcode = dp_ir[6:0];
  assign inst_funct3 = dp_ir[14:12];
  assign inst_funct7 = dp_ir[31:25];

  function automatic logic [31:0] dp_alu(input logic [4:0] fn, input logic [31:0] a, b);
    case (fn)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'd0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb begin
    dp_imm = imm_of(dp_ir);
    alu_a  = (alu_operand_a_select == OPA_PC) ? dp_pc : dp_rs1;
    case (alu_operand_b_select)
      OPB_RS2:  alu_b = dp_rs2;
      OPB_IMM:  alu_b = dp_imm;
      OPB_FOUR: alu_b = 32'd4;
      default:  alu_b = 32'd0;
    endcase
    alu_result = dp_alu(alu_function, alu_a, alu_b);
    mem_rdata  = inst_or_data ? dmem[dp_alu_out[7:2]] : imem[dp_pc[7:2]];
    case (reg_writeback_select)
      WB_ALU_OUT: wb_value = dp_alu_out;
      WB_DATA:    wb_value = dp_data;
      WB_PC:      wb_value = dp_pc;
      WB_IMM:     wb_value = dp_imm;
      default:    wb_value = 32'd0;
    endcase
    next_pc = (next_pc_select == NPC_ALU_OUT) ? dp_alu_out : (alu_result & ~32'd1);
  end
  assign alu_result_equal_zero = (alu_result == 32'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) dp_pc <= 32'd0;
    else if (pc_write_enable) dp_pc <= next_pc;
  end

  always_ff @(posedge clock) begin
    if (inst_write_enable) dp_ir <= mem_rdata;
    if (alu_out_write_enable) dp_alu_out <= alu_result;
    if (data_write_enable) dp_data <= mem_rdata;
    dp_rs1 <= dp_rf[dp_ir[19:15]];
    dp_rs2 <= dp_rf[dp_ir[24:20]];
    if (dp_clear) begin
      for (int i = 0; i < 32; i++) dp_rf[i] <= 32'd0;
      for (int i = 0; i < 64; i++) dmem[i] <= 32'd0;
    end else begin
      if (regfile_write_enable && dp_ir[11:7] != 5'd0) dp_rf[dp_ir[11:7]] <= wb_value;
      if (mem_write_enable && inst_or_data) dmem[dp_alu_out[7:2]] <= dp_rs2;
    end
  end

  // ---------------- instruction-level reference model ----------------
  logic [31:0] ref_pc;
  logic [31:0] ref_rf [32];
  logic [31:0] ref_dmem [64];

  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, b);
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic ref_step(input logic [31:0] ins, output int cyc);
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] a, b, imm, npc, addr, res;
    logic        wr, taken;
    rd = ins[11:7]; f3 = ins[14:12];
    a = ref_rf[ins[19:15]]; b = ref_rf[ins[24:20]];
    imm = imm_of(ins); npc = ref_pc + 32'd4; wr = 1'b0; res = 32'd0; cyc = 4;
    case (ins[6:0])
      OPC_OP:     begin wr = 1; res = ref_alu(f3, ins[30], a, b); end
      OPC_OP_IMM: begin wr = 1; res = ref_alu(f3, f3 == 3'd5 && ins[30], a, imm); end
      OPC_LUI:    begin wr = 1; res = imm; cyc = 3; end
      OPC_AUIPC:  begin wr = 1; res = ref_pc + imm; end
      OPC_LOAD:   begin addr = a + imm; wr = 1; res = ref_dmem[addr[7:2]]; cyc = 5; end
      OPC_STORE:  begin addr = a + imm; ref_dmem[addr[7:2]] = b; end
      OPC_BRANCH: begin
        case (f3)
          3'd0: taken = (a == b);
          3'd1: taken = (a != b);
          3'd4: taken = $signed(a) < $signed(b);
          3'd5: taken = $signed(a) >= $signed(b);
          3'd6: taken = a < b;
          default: taken = a >= b;
        endcase
        if (taken) npc = ref_pc + imm;
      end
      OPC_JAL:    begin wr = 1; res = ref_pc + 32'd4; npc = ref_pc + imm; end
      OPC_JALR:   begin wr = 1; res = ref_pc + 32'd4; npc = (a + imm) & ~32'd1; end
      default:    cyc = 3;
    endcase
    if (wr && rd != 5'd0) ref_rf[rd] = res;
    ref_pc = npc;
  endtask

  // Runs one instruction placed at the model's PC; returns cycles up to and
  // including the one that writes the PC.
  task automatic run_instr(input logic [31:0] ins, output int cyc);
    logic done;
    imem[ref_pc[7:2]] = ins;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 20) begin
      @(negedge clock);
      cyc++;
      done = pc_write_enable;
      @(posedge clock);
    end
    #1;
    if (!done) check("instr_timeout", {31'd0, done}, 32'd1);
  endtask

  function automatic logic [31:0] gen_random(input logic [31:0] pc);
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] r, tgt;
    logic [2:0]  bf [6];
    bf = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    rd = 5'($urandom_range(0, 7)); rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
    f3 = 3'($urandom_range(0, 7)); r = $urandom;
    tgt = 32'($urandom_range(0, 63)) * 32'd4;
    case ($urandom_range(0, 9))
      0: return enc_r(((f3 == 3'd0 || f3 == 3'd5) && r[0]) ? 7'h20 : 7'h00, rs2, rs1, f3, rd);
      1: begin
        if (f3 == 3'd1) r = {27'd0, r[4:0]};
        else if (f3 == 3'd5) r = {20'd0, 1'b0, r[10], 5'd0, r[4:0]};
        return enc_i(r, rs1, f3, rd, OPC_OP_IMM);
      end
      2: return enc_u(r, rd, OPC_LUI);
      3: return enc_u(r, rd, OPC_AUIPC);
      4: return enc_i(tgt, 5'd0, 3'b010, rd, OPC_LOAD);
      5: return enc_s(tgt, rs2, 5'd0);
      6: return enc_b(tgt - pc, rs2, rs1, bf[$urandom_range(0, 5)]);
      7: return enc_j(tgt - pc, rd);
      8: return enc_i(tgt, 5'd0, 3'd0, rd, OPC_JALR);
      default: return enc_i(32'd0, 5'd0, 3'd0, 5'd0, OPC_MISC_MEM);
    endcase
  endfunction

  typedef struct {
    logic [31:0] ins;
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs [20];

  initial begin
    int cyc, rcyc;
    logic [31:0] ins;
    logic [4:0]  rd;

    vecs[0]  = '{enc_i(32'd5, 5'd0, 3'd0, 5'd1, OPC_OP_IMM), 4, 5'd1, 32'd5, 32'd4};
    vecs[1]  = '{enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2), 4, 5'd2, 32'd10, 32'd8};
    vecs[2]  = '{enc_u(32'd1, 5'd6, OPC_AUIPC), 4, 5'd6, 32'h1008, 32'd12};
    vecs[3]  = '{enc_s(32'd0, 5'd2, 5'd0), 4, 5'd2, 32'd10, 32'd16};
    vecs[4]  = '{enc_b(32'd8, 5'd0, 5'd0, 3'd0), 4, 5'd0, 32'd0, 32'd24};
    vecs[5]  = '{enc_i(32'd0, 5'd0, 3'b010, 5'd3, OPC_LOAD), 5, 5'd3, 32'd10, 32'd28};
    vecs[6]  = '{enc_b(32'd8, 5'd0, 5'd0, 3'd1), 4, 5'd0, 32'd0, 32'd32};
    vecs[7]  = '{enc_j(32'd12, 5'd1), 4, 5'd1, 32'd36, 32'd44};
    vecs[8]  = '{enc_i(32'd40, 5'd0, 3'd0, 5'd1, OPC_OP_IMM), 4, 5'd1, 32'd40, 32'd48};
    vecs[9]  = '{enc_i(32'd5, 5'd1, 3'd0, 5'd1, OPC_JALR), 4, 5'd1, 32'd52, 32'd44};
    vecs[10] = '{enc_u(32'h12345, 5'd5, OPC_LUI), 3, 5'd5, 32'h1234_5000, 32'd48};
    vecs[11] = '{enc_i(32'hFFFF_FFFF, 5'd0, 3'd0, 5'd7, OPC_OP_IMM), 4, 5'd7, 32'hFFFF_FFFF, 32'd52};
    vecs[12] = '{enc_i(32'd1, 5'd0, 3'd0, 5'd8, OPC_OP_IMM), 4, 5'd8, 32'd1, 32'd56};
    vecs[13] = '{enc_b(32'd8, 5'd8, 5'd7, 3'd4), 4, 5'd7, 32'hFFFF_FFFF, 32'd64};
    vecs[14] = '{enc_i(32'd0, 5'd0, 3'd0, 5'd0, OPC_MISC_MEM), 3, 5'd0, 32'd0, 32'd68};
    vecs[15] = '{enc_b(-32'sd68, 5'd8, 5'd7, 3'd7), 4, 5'd8, 32'd1, 32'd0};
    vecs[16] = '{enc_r(7'h20, 5'd7, 5'd8, 3'd0, 5'd9), 4, 5'd9, 32'd2, 32'd4};
    vecs[17] = '{enc_i(32'h404, 5'd7, 3'd5, 5'd10, OPC_OP_IMM), 4, 5'd10, 32'hFFFF_FFFF, 32'd8};
    vecs[18] = '{enc_i(32'd28, 5'd7, 3'd5, 5'd11, OPC_OP_IMM), 4, 5'd11, 32'h0000_000F, 32'd12};
    vecs[19] = '{enc_b(32'd8, 5'd8, 5'd7, 3'd5), 4, 5'd7, 32'hFFFF_FFFF, 32'd16};

    ref_pc = 32'd0;
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
    for (int i = 0; i < 64; i++) begin ref_dmem[i] = 32'd0; imem[i] = 32'd0; end

    // Reset: everything quiet, then a fetch in the first cycle after release
    reset = 1'b1; dp_clear = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("reset_enables", {25'd0, pc_write_enable, alu_out_write_enable, inst_write_enable,
          data_write_enable, regfile_write_enable, mem_read_enable, mem_write_enable}, 32'd0);
    check("reset_illegal", {31'd0, illegal_inst}, 32'd0);
    dp_clear = 1'b0; reset = 1'b0;
    #1;
    check("first_fetch", {28'd0, mem_read_enable, inst_write_enable, inst_or_data,
          alu_out_write_enable}, 32'b1100);

    for (int i = 0; i < 20; i++) begin
      run_instr(vecs[i].ins, cyc);
      ref_step(vecs[i].ins, rcyc);
      check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].cyc));
      check($sformatf("vec%0d_pc", i), dp_pc, vecs[i].pc);
      check($sformatf("vec%0d_x%0d", i, vecs[i].rd), dp_rf[vecs[i].rd], vecs[i].val);
    end

    // Reset while the load is reading memory: no write to x12, PC back to 0
    imem[ref_pc[7:2]] = enc_i(32'd0, 5'd0, 3'b010, 5'd12, OPC_LOAD);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("midload_state", {30'd0, mem_read_enable, inst_or_data}, 32'b11);
    reset = 1'b1;
    #1;
    check("midload_reset_enables", {25'd0, pc_write_enable, alu_out_write_enable,
          inst_write_enable, data_write_enable, regfile_write_enable, mem_read_enable,
          mem_write_enable}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    ref_pc = 32'd0;
    check("midload_x12", dp_rf[12], 32'd0);
    check("midload_pc", dp_pc, 32'd0);
    ins = enc_i(32'd77, 5'd0, 3'd0, 5'd12, OPC_OP_IMM);
    run_instr(ins, cyc);
    ref_step(ins, rcyc);
    check("restart_cycles", 32'(cyc), 32'd4);
    check("restart_pc", dp_pc, 32'd4);
    check("restart_x12", dp_rf[12], 32'd77);

    // Illegal opcode parks in TRAP with the PC frozen
    imem[ref_pc[7:2]] = 32'h0000_007F;
    repeat (6) @(negedge clock);
    check("trap_illegal", {31'd0, illegal_inst}, 32'd1);
    check("trap_no_pc_write", {31'd0, pc_write_enable}, 32'd0);
    check("trap_pc", dp_pc, ref_pc);
    reset = 1'b1;
    #1;
    check("trap_cleared", {31'd0, illegal_inst}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    ref_pc = 32'd0;

    for (int n = 0; n < 300; n++) begin
      ins = gen_random(ref_pc);
      rd  = ins[11:7];
      run_instr(ins, cyc);
      ref_step(ins, rcyc);
      check($sformatf("rnd%0d_cycles ins=%h", n, ins), 32'(cyc), 32'(rcyc));
      check($sformatf("rnd%0d_pc ins=%h", n, ins), dp_pc, ref_pc);
      check($sformatf("rnd%0d_rd ins=%h", n, ins), dp_rf[rd], ref_rf[rd]);
    end

    for (int i = 0; i < 16; i++)
      check($sformatf("final_x%0d", i), dp_rf[i], ref_rf[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
